efx_simple_dual_port_ram: RTL and testbench
===========================================

EFX_SIMPLE_DUAL_PORT_RAM -- requirements
Module: efx_simple_dual_port_ram

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DATA_WIDTH_A, 8, write-port data width.
- ADDR_WIDTH_A, 4, write-port address width.
- DATA_WIDTH_B, 16, read-port data width.
- ADDR_WIDTH_B, 3, read-port address width.
- BYTEEN_WIDTH, 2, byte-enable width; lane k covers wdata[8k+7:8k].
- OUTPUT_REG, 0, 1 = extra rdata pipeline register.
- WRITE_MODE, "READ_FIRST", same-address read/write collision policy.
- WE_POLARITY / RE_POLARITY / WCLKE_POLARITY / BYTEEN_POLARITY / WADDREN_POLARITY / RADDREN_POLARITY, 1 each, 1 = active-high, 0 = active-low.
- WE_ENABLE / RE_ENABLE / WCLKE_ENABLE / BYTEEN_ENABLE / WADDREN_ENABLE / RADDREN_ENABLE, 1 each, 0 = input ignored and treated as permanently active.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock for both ports.
- reset, in, 1, synchronous active-high reset.
- wclke, in, 1, write clock enable.
- we, in, 1, write enable.
- byteen, in, BYTEEN_WIDTH, per-lane write enable.
- waddren, in, 1, write-address load enable.
- waddr, in, ADDR_WIDTH_A, write address.
- wdata, in, DATA_WIDTH_A, write data.
- re, in, 1, read enable.
- raddren, in, 1, read-address load enable.
- raddr, in, ADDR_WIDTH_B, read address.
- rdata, out, DATA_WIDTH_B, read data.
REQ-003 One clock; reset is synchronous and active-high. All logic is on the rising edge of clk; there are no other clocks and no asynchronous paths.

Function
REQ-004 Capacity SHALL satisfy DATA_WIDTH_A*2^ADDR_WIDTH_A == DATA_WIDTH_B*2^ADDR_WIDTH_B. The port width ratio SHALL be a power of two from 1 to 32.
REQ-005 Memory SHALL be modelled as a flat bit array. Write word a occupies bits [a*DATA_WIDTH_A +: DATA_WIDTH_A]. Read word r occupies bits [r*DATA_WIDTH_B +: DATA_WIDTH_B], so lower addresses map to lower-order bits (for example, rdata(r) = {wordA[2r+1], wordA[2r]} at defaults).
REQ-006 Write condition: wclke active AND we active. Only lanes with byteen active are updated; lanes outside DATA_WIDTH_A are ignored. With width 8, only byteen[0] applies.
REQ-007 Effective write address: if waddren is active, waddr; otherwise the last latched waddr, which holds its value. The same rule, using raddren and raddr, gives the effective read address.
REQ-008 Read: when re is active at a rising edge, rdata SHALL present the word at the effective read address after that edge (1-cycle latency with OUTPUT_REG=0, 2 cycles with OUTPUT_REG=1). When re is inactive, rdata holds its value.
REQ-009 Same-edge read and write to overlapping bits in READ_FIRST mode: rdata SHALL return the pre-write contents, and the write completes normally.
REQ-010 Memory contents SHALL be undefined (X) after power-up; there is no initialisation file.

Reset
REQ-011 While reset is high at a rising edge: rdata and the output pipeline register clear to 0 and the latched address registers clear to 0. No write occurs on that edge. Memory contents are retained.
REQ-012 Reset mid-read: rdata SHALL be 0 after the reset edge, and the first read after reset deasserts SHALL return correct stored data.

Verification
REQ-013 Write sweep: write wdata=8'h10+a at a=0..15 (byteen=2'b11, wclke=we=waddren=1), then read r=0..7 with re=raddren=1. Required: rdata=16'h1110 for r=0, 16'h1312 for r=1, through 16'h1F1E for r=7, each one cycle after the read edge.
REQ-014 Byte enable: after the sweep, write a=0 with 8'hAA and byteen=2'b00. Required: reading r=0 still returns 16'h1110.
REQ-015 Read-enable hold: read r=7 (rdata=16'h1F1E), then drop re and change raddr to 0. Required: rdata stays 16'h1F1E.
REQ-016 Collision: read r=1 while writing a=2 with 8'h55 on the same edge. Required: rdata=16'h1312, and the following read of r=1 returns 16'h1355.
REQ-017 Address enable: latch waddr=3, then write 8'h77 with waddren=0 and waddr=9. Required: word 3 becomes 8'h77 and word 9 is unchanged.
REQ-018 Reset mid-read: assert reset for one edge while rdata=16'h1F1E. Required: rdata=0 on the next cycle, and a subsequent read of r=7 returns 16'h1F1E.

Source files
------------

// File: rtl/efx_simple_dual_port_ram.sv
// Simple dual-port RAM with one clock: a byte-enabled write port and a read port of a
// different width, both addressing one flat bit array.
module efx_simple_dual_port_ram #(
  parameter int    DATA_WIDTH_A     = 8,
  parameter int    ADDR_WIDTH_A     = 4,
  parameter int    DATA_WIDTH_B     = 16,
  parameter int    ADDR_WIDTH_B     = 3,
  parameter int    BYTEEN_WIDTH     = 2,
  parameter int    OUTPUT_REG       = 0,
  parameter string WRITE_MODE       = "READ_FIRST",
  parameter bit    WE_POLARITY      = 1'b1,
  parameter bit    RE_POLARITY      = 1'b1,
  parameter bit    WCLKE_POLARITY   = 1'b1,
  parameter bit    BYTEEN_POLARITY  = 1'b1,
  parameter bit    WADDREN_POLARITY = 1'b1,
  parameter bit    RADDREN_POLARITY = 1'b1,
  parameter bit    WE_ENABLE        = 1'b1,
  parameter bit    RE_ENABLE        = 1'b1,
  parameter bit    WCLKE_ENABLE     = 1'b1,
  parameter bit    BYTEEN_ENABLE    = 1'b1,
  parameter bit    WADDREN_ENABLE   = 1'b1,
  parameter bit    RADDREN_ENABLE   = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wclke,
  input  logic                    we,
  input  logic [BYTEEN_WIDTH-1:0] byteen,
  input  logic                    waddren,
  input  logic [ADDR_WIDTH_A-1:0] waddr,
  input  logic [DATA_WIDTH_A-1:0] wdata,
  input  logic                    re,
  input  logic                    raddren,
  input  logic [ADDR_WIDTH_B-1:0] raddr,
  output logic [DATA_WIDTH_B-1:0] rdata
);

  localparam int TOTAL_BITS = DATA_WIDTH_A * (1 << ADDR_WIDTH_A);
  localparam int IDX_W      = (TOTAL_BITS > 1) ? $clog2(TOTAL_BITS) : 1;
  localparam int WIDE       = (DATA_WIDTH_A > DATA_WIDTH_B) ? DATA_WIDTH_A : DATA_WIDTH_B;
  localparam int NARROW     = (DATA_WIDTH_A > DATA_WIDTH_B) ? DATA_WIDTH_B : DATA_WIDTH_A;
  localparam int RATIO      = WIDE / NARROW;
  localparam bit MODE_WF    = (WRITE_MODE == "WRITE_FIRST");
  localparam bit MODE_NC    = (WRITE_MODE == "NO_CHANGE");

  if (DATA_WIDTH_A * (1 << ADDR_WIDTH_A) != DATA_WIDTH_B * (1 << ADDR_WIDTH_B)) begin : g_cap_err
    $error("efx_simple_dual_port_ram: port capacities differ");
  end
  if ((WIDE % NARROW) != 0 || RATIO > 32 || (RATIO & (RATIO - 1)) != 0) begin : g_ratio_err
    $error("efx_simple_dual_port_ram: width ratio must be a power of two up to 32");
  end

  // Control decode: a disabled control input reads as permanently active.
  logic                    wclke_act, we_act, re_act, waddren_act, raddren_act;
  logic [BYTEEN_WIDTH-1:0] byteen_act;

  assign wclke_act   = !WCLKE_ENABLE   || (wclke   == WCLKE_POLARITY);
  assign we_act      = !WE_ENABLE      || (we      == WE_POLARITY);
  assign re_act      = !RE_ENABLE      || (re      == RE_POLARITY);
  assign waddren_act = !WADDREN_ENABLE || (waddren == WADDREN_POLARITY);
  assign raddren_act = !RADDREN_ENABLE || (raddren == RADDREN_POLARITY);
  assign byteen_act  = BYTEEN_ENABLE ? ~(byteen ^ {BYTEEN_WIDTH{BYTEEN_POLARITY}})
                                     : {BYTEEN_WIDTH{1'b1}};

  // Address latches; the load enable selects the live address combinationally.
  logic [ADDR_WIDTH_A-1:0] waddr_q, waddr_eff;
  logic [ADDR_WIDTH_B-1:0] raddr_q, raddr_eff;

  assign waddr_eff = waddren_act ? waddr : waddr_q;
  assign raddr_eff = raddren_act ? raddr : raddr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      waddr_q <= '0;
      raddr_q <= '0;
    end else begin
      if (waddren_act) waddr_q <= waddr;
      if (raddren_act) raddr_q <= raddr;
    end
  end

  // Per-bit write enable; bits beyond the byte-enable lanes are always written.
  logic [DATA_WIDTH_A-1:0] bit_en;

  for (genvar i = 0; i < DATA_WIDTH_A; i++) begin : g_bit_en
    if ((i / 8) < BYTEEN_WIDTH) begin : g_lane
      assign bit_en[i] = byteen_act[i / 8];
    end else begin : g_free
      assign bit_en[i] = 1'b1;
    end
  end

  logic [IDX_W-1:0] wbase, rbase;
  logic             wr_act;

  assign wbase  = IDX_W'(int'(waddr_eff) * DATA_WIDTH_A);
  assign rbase  = IDX_W'(int'(raddr_eff) * DATA_WIDTH_B);
  assign wr_act = wclke_act && we_act && !reset;

  // Storage has no reset and no init: contents start undefined and survive reset.
  logic [TOTAL_BITS-1:0] mem;

  always_ff @(posedge clk) begin
    if (wr_act) begin
      for (int i = 0; i < DATA_WIDTH_A; i++) begin
        if (bit_en[i]) mem[wbase + IDX_W'(i)] <= wdata[i];
      end
    end
  end

  // Collision detection walks the read word; the offset into the write word wraps
  // to a large value when the bit lies outside it, so the shift yields 0 there.
  logic [DATA_WIDTH_B-1:0] rd_word;
  logic                    collide;
  logic [IDX_W-1:0]        off;
  logic                    en_bit, wd_bit;

  always_comb begin
    rd_word = mem[rbase +: DATA_WIDTH_B];
    collide = 1'b0;
    off     = '0;
    en_bit  = 1'b0;
    wd_bit  = 1'b0;
    if (wr_act) begin
      for (int j = 0; j < DATA_WIDTH_B; j++) begin
        off    = rbase + IDX_W'(j) - wbase;
        en_bit = 1'(bit_en >> off);
        wd_bit = 1'(wdata >> off);
        if (en_bit) begin
          collide = 1'b1;
          if (MODE_WF) rd_word[j] = wd_bit;
        end
      end
    end
  end

  logic                    rd_take;
  logic [DATA_WIDTH_B-1:0] rd_q;

  assign rd_take = re_act && !(MODE_NC && collide);

  always_ff @(posedge clk) begin
    if (reset)        rd_q <= '0;
    else if (rd_take) rd_q <= rd_word;
  end

  if (OUTPUT_REG != 0) begin : g_oreg
    logic [DATA_WIDTH_B-1:0] out_q;
    always_ff @(posedge clk) begin
      if (reset) out_q <= '0;
      else       out_q <= rd_q;
    end
    assign rdata = out_q;
  end else begin : g_no_oreg
    assign rdata = rd_q;
  end

  logic unused_ok;
  assign unused_ok = ^{wclke, we, re, waddren, raddren, byteen, byteen_act};

endmodule

// File: tb/tb_efx_simple_dual_port_ram.sv
// Bench for efx_simple_dual_port_ram at default parameters: directed literal checks
// plus randomized traffic compared every cycle against a byte-array model.
module tb_efx_simple_dual_port_ram;
  logic        clk = 1'b0;
  logic        reset, wclke, we, waddren, re, raddren;
  logic [1:0]  byteen;
  logic [3:0]  waddr;
  logic [7:0]  wdata;
  logic [2:0]  raddr;
  logic [15:0] rdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  efx_simple_dual_port_ram dut (
    .clk(clk), .reset(reset), .wclke(wclke), .we(we), .byteen(byteen),
    .waddren(waddren), .waddr(waddr), .wdata(wdata), .re(re),
    .raddren(raddren), .raddr(raddr), .rdata(rdata)
  );

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: write words are bytes; read word r is {byte 2r+1, byte 2r}.
  logic [7:0]  mb [16];
  bit          kn [16];
  int          m_wa = 0, m_ra = 0;
  logic [15:0] exp_rd = '0;
  bit          exp_ok = 1'b0;

  always @(posedge clk) begin : model
    int wa, ra;
    if (reset) begin
      m_wa = 0; m_ra = 0; exp_rd = '0; exp_ok = 1'b1;
    end else begin
      wa = waddren ? int'(waddr) : m_wa;
      ra = raddren ? int'(raddr) : m_ra;
      m_wa = wa;
      m_ra = ra;
      if (re) begin
        exp_rd = {mb[2*ra+1], mb[2*ra]};
        exp_ok = kn[2*ra] && kn[2*ra+1];
      end
      if (wclke && we && byteen[0]) begin
        mb[wa] = wdata;
        kn[wa] = 1'b1;
      end
    end
  end

  always @(negedge clk) if (exp_ok) chk("rdata_vs_model", rdata, exp_rd);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wclke = 0; we = 0; byteen = 2'b00; waddren = 0; re = 0; raddren = 0;
  endtask

  initial begin
    reset = 1; idle(); waddr = '0; wdata = '0; raddr = '0;
    step(); step();
    reset = 0;
    chk("reset_rdata", rdata, 16'h0000);

    // Write sweep then read back every read word.
    for (int a = 0; a < 16; a++) begin
      wclke = 1; we = 1; waddren = 1; byteen = 2'b11;
      waddr = 4'(a); wdata = 8'h10 + 8'(a);
      step();
    end
    idle();
    for (int r = 0; r < 8; r++) begin
      re = 1; raddren = 1; raddr = 3'(r);
      step();
      chk("sweep_read", rdata, 16'h1110 + 16'(r) * 16'h0202);
    end

    // Byte enables all off: word 0 must not change.
    idle();
    wclke = 1; we = 1; waddren = 1; waddr = 4'd0; wdata = 8'hAA; byteen = 2'b00;
    step();
    idle(); re = 1; raddren = 1; raddr = 3'd0;
    step();
    chk("byteen_off", rdata, 16'h1110);

    // Read-enable hold.
    raddr = 3'd7;
    step();
    chk("read_r7", rdata, 16'h1F1E);
    re = 0; raddr = 3'd0;
    step();
    chk("re_hold_1", rdata, 16'h1F1E);
    step();
    chk("re_hold_2", rdata, 16'h1F1E);

    // Same-edge collision returns old data; write still lands.
    re = 1; raddren = 1; raddr = 3'd1;
    wclke = 1; we = 1; waddren = 1; waddr = 4'd2; wdata = 8'h55; byteen = 2'b11;
    step();
    chk("collide_old", rdata, 16'h1312);
    we = 0;
    step();
    chk("collide_new", rdata, 16'h1355);

    // Write-address latch: address 9 presented with waddren low is ignored.
    idle(); wclke = 1; waddren = 1; waddr = 4'd3;
    step();
    waddren = 0; waddr = 4'd9; we = 1; wdata = 8'h77; byteen = 2'b11;
    step();
    idle(); re = 1; raddren = 1; raddr = 3'd1;
    step();
    chk("waddr_latch_w3", rdata, 16'h7755);
    raddr = 3'd4;
    step();
    chk("waddr_latch_w9", rdata, 16'h1918);

    // Reset mid-read; the read-address latch is cleared too.
    raddr = 3'd7;
    step();
    chk("pre_reset_r7", rdata, 16'h1F1E);
    re = 0; reset = 1;
    step();
    reset = 0;
    chk("reset_mid_read", rdata, 16'h0000);
    re = 1; raddren = 0; raddr = 3'd7;
    step();
    chk("raddr_latch_cleared", rdata, 16'h1110);
    raddren = 1;
    step();
    chk("post_reset_r7", rdata, 16'h1F1E);

    // Randomized traffic, checked by the model every cycle.
    for (int n = 0; n < 600; n++) begin
      reset   = ($urandom_range(0, 49) == 0);
      wclke   = ($urandom_range(0, 3) != 0);
      we      = 1'($urandom);
      byteen  = 2'($urandom);
      waddren = ($urandom_range(0, 3) != 0);
      waddr   = 4'($urandom);
      wdata   = 8'($urandom);
      re      = 1'($urandom);
      raddren = ($urandom_range(0, 3) != 0);
      raddr   = 3'($urandom);
      step();
    end
    reset = 0; idle();
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
